// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath width, canonical NOP, opcodes and the fetch buffer entry.
package cpu_pkg;
   localparam int          XLEN      = 32;
   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   localparam logic [6:0] OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;

   typedef struct packed {
      logic [XLEN-1:0] instr;
      logic [XLEN-1:0] pc;
   } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of fetched {instr, pc} entries; flush wins over push/pop.
module fetch_fifo
   import cpu_pkg::*;
#(
   parameter  int DEPTH = 2,
   localparam int CW    = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          flush,
   input  logic          push,
   input  fetch_entry_t  din,
   input  logic          pop,
   output fetch_entry_t  head,
   output logic [CW-1:0] count,
   output logic          empty
);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   fetch_entry_t    mem [DEPTH];
   logic [AW-1:0]   wr_ptr, rd_ptr;
   logic            full;

   function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
      return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
   endfunction

   assign head  = mem[rd_ptr];
   assign empty = (count == '0);
   assign full  = (count == CW'(DEPTH));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= din;
            wr_ptr      <= nxt(wr_ptr);
         end
         if (pop) rd_ptr <= nxt(rd_ptr);
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // The issue credit must make this unreachable
   a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
      !(push && full && !pop && !flush));
endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch front end: owns PCF, issues credit-limited word reads,
// drops wrong-path responses after a redirect and feeds decode from a small buffer.
module fetch_stage
   import cpu_pkg::*;
#(
   parameter int              XLEN     = cpu_pkg::XLEN,
   parameter int              DEPTH    = 2,
   parameter logic [XLEN-1:0] RESET_PC = '0
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            PCSrc,
   input  logic [XLEN-1:0] PCTarget,
   input  logic            StallD,
   output logic            ImemReqValid,
   input  logic            ImemReqReady,
   output logic [XLEN-1:0] ImemAddr,
   input  logic            ImemRspValid,
   input  logic [XLEN-1:0] ImemRspData,
   output logic            ValidD,
   output logic [XLEN-1:0] InstrD,
   output logic [XLEN-1:0] PCD,
   output logic [XLEN-1:0] PCPlus4D
);
   localparam int CW = $clog2(DEPTH + 1);
   localparam int DW = 8;

   logic [XLEN-1:0] pcf, rsp_pc, tgt_pc;
   logic [CW-1:0]   live_cnt, occ;
   logic [DW-1:0]   drop_cnt;
   logic            issue, keep_rsp, rsp_drop, pop, empty;
   fetch_entry_t    din, head;

   // live_cnt counts only right-path requests; wrong-path ones migrate to drop_cnt
   assign ImemReqValid = rst_n && !PCSrc &&
                         (({1'b0, live_cnt} + {1'b0, occ}) < (CW + 1)'(DEPTH));
   assign ImemAddr     = pcf;
   assign issue        = ImemReqValid && ImemReqReady;
   assign keep_rsp     = ImemRspValid && (drop_cnt == '0) && !PCSrc;
   assign rsp_drop     = ImemRspValid && ((drop_cnt != '0) || (live_cnt != '0));
   assign tgt_pc       = PCTarget & ~XLEN'(3);

   // Kept responses are consecutive words from the last redirect target,
   // so a single running PC stands in for a per-request PC queue.
   assign din.instr = ImemRspData;
   assign din.pc    = rsp_pc;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pcf      <= RESET_PC;
         rsp_pc   <= RESET_PC;
         live_cnt <= '0;
         drop_cnt <= '0;
      end else if (PCSrc) begin
         pcf      <= tgt_pc;
         rsp_pc   <= tgt_pc;
         live_cnt <= '0;
         drop_cnt <= drop_cnt + DW'(live_cnt) - DW'(rsp_drop);
      end else begin
         if (issue)    pcf    <= pcf + XLEN'(4);
         if (keep_rsp) rsp_pc <= rsp_pc + XLEN'(4);
         live_cnt <= live_cnt + CW'(issue) - CW'(keep_rsp);
         if (ImemRspValid && (drop_cnt != '0)) drop_cnt <= drop_cnt - DW'(1);
      end
   end

   assign ValidD = !empty;
   assign pop    = ValidD && !StallD && !PCSrc;

   fetch_fifo #(.DEPTH(DEPTH)) u_buf (
      .clk   (clk),
      .rst_n (rst_n),
      .flush (PCSrc),
      .push  (keep_rsp),
      .din   (din),
      .pop   (pop),
      .head  (head),
      .count (occ),
      .empty (empty)
   );

   assign InstrD   = ValidD ? head.instr : NOP_INSTR;
   assign PCD      = ValidD ? head.pc : RESET_PC;
   assign PCPlus4D = PCD + XLEN'(4);
endmodule
